dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the pipeline's MEM stage (CPU port) and an auxiliary master (loader/DMA port). The CPU port has priority. A wait counter guarantees the auxiliary master service within a bounded time. A bounded lock mode lets the auxiliary master run short bursts. The block sits between the MEM stage / aux master and the data memory's MemRead/MemWrite/address/write_data/read_data port, and it drives the CPU stall request.

## Interface
- ADDR_W, 32: address width passed through to memory.
- MAX_WAIT, 4: number of consecutive denied aux cycles before aux is force-granted. Must be 1..15.
- MAX_BURST, 8: maximum grants per aux lock. Must be 1..15.

- clk  in  1  clock; memory writes commit on posedge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request from the MEM stage.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_rdata  out  32  read data; 0 unless cpu_gnt & ~cpu_we.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rdata: same meaning for the aux port.
- aux_lock  in  1  aux requests to keep ownership after this grant.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  to memory address; 0 when idle.
- mem_wdata  out  32  to memory write_data; 0 when idle.
- mem_rdata  in  32  from memory read_data (combinational).

## Operation
- State registers:
  - state ∈ {S_PRIO_CPU, S_AUX_LOCK}.
  - wait_cnt: 4 bits, saturating.
  - burst_cnt: 4 bits.
- Reset: state=S_PRIO_CPU, wait_cnt=0, burst_cnt=0. While reset is high, every grant, mem_read, mem_write, mem_addr, mem_wdata, rdata and stall output is 0.
- Grant (combinational, at most one grant per cycle):
  - S_PRIO_CPU: aux_gnt = aux_req & (~cpu_req | wait_cnt==MAX_WAIT). cpu_gnt = cpu_req & ~aux_gnt.
  - S_AUX_LOCK: aux_gnt = aux_req. cpu_gnt = cpu_req & ~aux_req.
- Mux: the granted port drives mem_addr and mem_wdata. mem_read = gnt & ~we. mem_write = gnt & we. mem_rdata is routed only to the granted reading port; the other port's rdata is 0.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when aux_req & ~aux_gnt.
  - Clears on aux_gnt or ~aux_req.
- Transitions:
  - S_PRIO_CPU → S_AUX_LOCK when aux_gnt & aux_lock & MAX_BURST>1. burst_cnt ← 1.
  - In S_AUX_LOCK, each aux grant does burst_cnt+1.
  - S_AUX_LOCK → S_PRIO_CPU at the clock edge where any of these holds: ~aux_req, ~aux_lock, or (aux_gnt & burst_cnt+1==MAX_BURST). burst_cnt ← 0 and wait_cnt ← 0 on this transition.
- After a burst limit exit, the next cycle is S_PRIO_CPU. The CPU therefore wins if it requests, unless wait_cnt==MAX_WAIT, which cannot happen because wait_cnt was cleared on exit.
- Simultaneous cpu_req & aux_req with wait_cnt<MAX_WAIT in S_PRIO_CPU: the CPU wins and wait_cnt increments.

## Timing
- Read path is zero-latency combinational: mem_rdata → rdata in the grant cycle.
- Writes commit at the posedge ending the grant cycle.
- A requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle. The access completes in that cycle.
- Worst-case aux latency from req to gnt is MAX_WAIT+1 cycles.
- Worst-case CPU stall from a lock is MAX_BURST cycles, plus 1 for a forced aux grant.
- Reset mid-burst: the lock is dropped asynchronously, and the first cycle after reset deasserts is S_PRIO_CPU with counters at 0.

## Structure
- Shared package/header dmem_arb_pkg: state encodings S_PRIO_CPU=1'b0 and S_AUX_LOCK=1'b1, and the counter width constant ARB_CNT_W=4.
- One natural sub-module: sat_counter (parameterised width and limit, with inc, clr, and a count output). It is instantiated for wait_cnt.
- burst_cnt stays inline because of its load-to-1 behaviour.

## Test plan
- Reset release with no requests: all outputs 0 and state S_PRIO_CPU. Reset asserted mid-lock → gnt 0 immediately.
- CPU write then read, addr 0x10, data 0xDEADBEEF, aux idle: write granted with no stall, then read returns 0xDEADBEEF in the same cycle and aux_rdata=0.
- cpu_req and aux_req held high continuously, MAX_WAIT=4: CPU granted in cycles 0–3, aux force-granted in cycle 4 with cpu_stall=1, then the pattern repeats every 5 cycles.
- aux_lock=1 with aux_req held and MAX_BURST=8, CPU requesting: aux is granted for 8 consecutive cycles, then the CPU is granted in cycle 9.
- aux_lock dropped after 3 grants: return to S_PRIO_CPU and the CPU is granted on the next cycle.
- Aux read of 0x20 and CPU idle: aux granted immediately; mem_addr=0x20 and mem_read=1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and counter width.
// The top and its saturating wait counter import these.
package dmem_arb_pkg;

    typedef enum logic {
        S_PRIO_CPU = 1'b0,
        S_AUX_LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_CNT_W = 4;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at LIMIT until cleared.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != LIMIT_V)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule : sat_counter

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU has priority, a wait
// counter bounds aux latency, and a bounded lock lets aux run short bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    input  logic              aux_lock,
    output logic              aux_gnt,
    output logic [31:0]       aux_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ARB_CNT_W-1:0] MAX_WAIT_V  = ARB_CNT_W'(MAX_WAIT);
    localparam logic [ARB_CNT_W-1:0] MAX_BURST_V = ARB_CNT_W'(MAX_BURST);
    localparam bit                   LOCK_EN     = (MAX_BURST > 1);

    arb_state_t           state_reg;
    arb_state_t           state_next;
    logic [ARB_CNT_W-1:0] burst_cnt_reg;
    logic [ARB_CNT_W-1:0] burst_cnt_next;
    logic [ARB_CNT_W-1:0] burst_cnt_inc;
    logic [ARB_CNT_W-1:0] wait_cnt;

    logic wait_full;
    logic lock_exit;
    logic cpu_gnt_int;
    logic aux_gnt_int;
    logic wait_inc;
    logic wait_clr;

    assign wait_full     = (wait_cnt == MAX_WAIT_V);
    assign burst_cnt_inc = burst_cnt_reg + 1'b1;

    // Grants are gated by reset so nothing reaches memory while reset is high.
    always_comb begin
        aux_gnt_int = 1'b0;
        cpu_gnt_int = 1'b0;
        if (!reset) begin
            if (state_reg == S_AUX_LOCK) begin
                aux_gnt_int = aux_req;
            end else begin
                aux_gnt_int = aux_req & (~cpu_req | wait_full);
            end
            cpu_gnt_int = cpu_req & ~aux_gnt_int;
        end
    end

    assign wait_inc = aux_req & ~aux_gnt_int;
    assign wait_clr = aux_gnt_int | ~aux_req | lock_exit;

    sat_counter #(
        .WIDTH (ARB_CNT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .count (wait_cnt)
    );

    // Lock entry already counts its first grant, hence the load to 1.
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        lock_exit      = 1'b0;
        case (state_reg)
            S_PRIO_CPU: begin
                if (aux_gnt_int && aux_lock && LOCK_EN) begin
                    state_next     = S_AUX_LOCK;
                    burst_cnt_next = 4'd1;
                end
            end
            S_AUX_LOCK: begin
                if (!aux_req || !aux_lock ||
                    (aux_gnt_int && (burst_cnt_inc == MAX_BURST_V))) begin
                    lock_exit      = 1'b1;
                    state_next     = S_PRIO_CPU;
                    burst_cnt_next = '0;
                end else if (aux_gnt_int) begin
                    burst_cnt_next = burst_cnt_inc;
                end
            end
            default: begin
                state_next     = S_PRIO_CPU;
                burst_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_PRIO_CPU;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // Memory-side mux; read data reaches only the granted reading port.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        aux_rdata = '0;
        if (cpu_gnt_int) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
                cpu_rdata = mem_rdata;
            end
        end else if (aux_gnt_int) begin
            mem_read  = ~aux_we;
            mem_write = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            if (!aux_we) begin
                aux_rdata = mem_rdata;
            end
        end
    end

    assign cpu_gnt   = cpu_gnt_int;
    assign aux_gnt   = aux_gnt_int;
    assign cpu_stall = ~reset & cpu_req & ~cpu_gnt_int;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: each cycle's expected grants and memory
// traffic are queued when driven and compared at the following negedge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        aux_req = 1'b0, aux_we = 1'b0, aux_lock = 1'b0;
    logic [31:0] aux_addr = '0, aux_wdata = '0;
    logic        aux_gnt;
    logic [31:0] aux_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [0:63];

    int total = 0;
    int bad   = 0;
    int txn   = 0;
    string scen = "init";

    typedef struct {
        logic        cg, ag, mr, mw, stall;
        logic [31:0] maddr, mwd, crd, ard;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (32),
        .MAX_WAIT  (4),
        .MAX_BURST (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .aux_req   (aux_req),
        .aux_we    (aux_we),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_lock  (aux_lock),
        .aux_gnt   (aux_gnt),
        .aux_rdata (aux_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory: combinational read, write at posedge.
    assign mem_rdata = tb_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // One arbitration cycle; entered and left 1 time unit after a posedge.
    task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic al, input logic ecg, input logic eag, input logic [31:0] erd);
        exp_t e, o;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad; aux_lock = al;
        e.cg = ecg; e.ag = eag; e.stall = cr & ~ecg;
        e.mr = 1'b0; e.mw = 1'b0; e.maddr = '0; e.mwd = '0; e.crd = '0; e.ard = '0;
        if (ecg) begin
            e.mr = ~cw; e.mw = cw; e.maddr = ca; e.mwd = cd;
            if (!cw) e.crd = erd;
        end else if (eag) begin
            e.mr = ~aw; e.mw = aw; e.maddr = aa; e.mwd = ad;
            if (!aw) e.ard = erd;
        end
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        $display("txn %0d %s cpu_gnt=%b aux_gnt=%b stall=%b addr=%h rd=%b wr=%b",
                 txn, scen, cpu_gnt, aux_gnt, cpu_stall, mem_addr, mem_read, mem_write);
        chk({scen, ".cpu_gnt"},   cpu_gnt,   o.cg);
        chk({scen, ".aux_gnt"},   aux_gnt,   o.ag);
        chk({scen, ".cpu_stall"}, cpu_stall, o.stall);
        chk({scen, ".mem_read"},  mem_read,  o.mr);
        chk({scen, ".mem_write"}, mem_write, o.mw);
        chk({scen, ".mem_addr"},  mem_addr,  o.maddr);
        chk({scen, ".mem_wdata"}, mem_wdata, o.mwd);
        chk({scen, ".cpu_rdata"}, cpu_rdata, o.crd);
        chk({scen, ".aux_rdata"}, aux_rdata, o.ard);
        txn++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = '0;

        // Requests present while reset is high must produce no activity.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
        aux_req = 1'b1;
        #2;
        scen = "in_reset";
        chk("in_reset.cpu_gnt",   cpu_gnt,   1'b0);
        chk("in_reset.aux_gnt",   aux_gnt,   1'b0);
        chk("in_reset.cpu_stall", cpu_stall, 1'b0);
        chk("in_reset.mem_write", mem_write, 1'b0);
        chk("in_reset.mem_addr",  mem_addr,  32'h0);
        chk("in_reset.mem_wdata", mem_wdata, 32'h0);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; aux_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        scen = "rst_idle";
        idle();

        scen = "cpu_wr";
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0);
        scen = "cpu_rd";
        cyc(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);

        // Continuous contention: every fifth cycle aux is force-granted.
        scen = "contend";
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 32'h30, 32'h1111, 1, 0, 32'h10, 0, 0,
                (i % 5) != 4, (i % 5) == 4, 32'hDEADBEEF);
        idle();

        // Full burst: 8 aux writes, CPU stalled until the ninth cycle.
        scen = "burst";
        for (int i = 0; i < 9; i++)
            cyc(i >= 1, 0, 32'h5C, 0, 1, 1, 32'h40 + 4 * i, i + 1, 1,
                i == 8, i < 8, 32'd8);
        idle();

        // Lock dropped on the third grant; CPU wins the next cycle.
        scen = "unlock";
        for (int i = 0; i < 4; i++)
            cyc(i >= 1, 0, 32'h40, 0, 1, 0, 32'h44, 0, i < 2,
                i == 3, i < 3, (i == 3) ? 32'd1 : 32'd2);
        idle();

        scen = "aux_wr";
        cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'hA5A50F0F, 0, 0, 1, 0);
        scen = "aux_rd";
        cyc(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 32'hA5A50F0F);

        // Reset mid-lock: grants drop at once and the lock does not survive.
        scen = "lock_enter";
        cyc(0, 0, 0, 0, 1, 1, 32'h80, 32'h7, 1, 0, 1, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cpu_wdata = '0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h84; aux_wdata = 32'h9; aux_lock = 1'b1;
        #1;
        chk("locked.aux_gnt",   aux_gnt,   1'b1);
        chk("locked.cpu_stall", cpu_stall, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst.aux_gnt",   aux_gnt,   1'b0);
        chk("mid_rst.cpu_gnt",   cpu_gnt,   1'b0);
        chk("mid_rst.cpu_stall", cpu_stall, 1'b0);
        chk("mid_rst.mem_write", mem_write, 1'b0);
        chk("mid_rst.mem_read",  mem_read,  1'b0);
        chk("mid_rst.mem_addr",  mem_addr,  32'h0);
        chk("mid_rst.mem_wdata", mem_wdata, 32'h0);
        chk("mid_rst.cpu_rdata", cpu_rdata, 32'h0);
        chk("mid_rst.aux_rdata", aux_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst.cpu_gnt",   cpu_gnt,   1'b1);
        chk("post_rst.aux_gnt",   aux_gnt,   1'b0);
        chk("post_rst.mem_addr",  mem_addr,  32'h80);
        chk("post_rst.cpu_rdata", cpu_rdata, 32'h7);
        @(posedge clk);
        #1;
        scen = "final_idle";
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
